instruction_fetch: RTL and testbench

Fetch stage for the single-issue MIPS datapath: owns the PC register, issues word reads to instruction memory over a req/ack handshake, and presents one instruction at a time (with its PC) to the instruction decoder. The next PC is computed when the decoder's consumer accepts the instruction, from the decode outputs fed back the same cycle: sequential, branch, jump, or jump-register. One instruction is in flight at most, so no speculation or flush exists.

---
 rtl/instruction_fetch.sv | 193 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage for the single-issue MIPS datapath.
// Owns the PC, issues one word read at a time over a req/ack handshake,
// and holds the returned instruction (with its PC) until the decoder's
// consumer accepts it. The next PC is chosen in the accept cycle from
// the decode results fed back for the held instruction.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   -> a misaligned next PC is loaded as-is and the stage
//                parks in FAULT with a sticky fault flag.
//   undefined -> next PC low bits are cleared; fault is tied low.

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // to decoder
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  // decode feedback for the held instruction
  input  logic        jump,
  input  logic        jumpLink,
  input  logic        jumpReg,
  input  logic        branchatall,
  input  logic        bne,
  input  logic        zero,
  input  logic [15:0] imm,
  input  logic [31:0] addr,
  input  logic [31:0] reg_rs,
  // status
  output logic [31:0] fetch_count,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
  logic        misaligned;
`endif

  logic        transfer;
  logic        branch_taken;
  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] target_raw;
  logic [31:0] next_pc;

  // The held instruction leaves only when both sides agree.
  assign transfer = instr_valid_q & instr_ready;

  // Next-PC selection: register jump beats absolute jump beats branch.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    branch_offset = {{14{imm[15]}}, imm, 2'b00};
    branch_target = pc_plus4 + branch_offset;
    branch_taken  = branchatall & (zero ^ bne);
    target_raw    = pc_plus4;
    if (jumpReg) begin
      target_raw = reg_rs;
    end else if (jump | jumpLink) begin
      target_raw = addr;
    end else if (branch_taken) begin
      target_raw = branch_target;
    end
`ifdef FETCH_ALIGN_CHECK_EN
    // Keep the raw target so a fault shows exactly where control went.
    next_pc    = target_raw;
    misaligned = |target_raw[1:0];
`else
    // Without checking, force word alignment so fetch never wanders.
    next_pc    = target_raw & 32'hFFFF_FFFC;
`endif
  end

  // Fetch sequencing: next-state and next-register values.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d       = fault_q;
`endif
    case (state_q)
      IDLE: begin
        // One quiet cycle after reset, then start the first read.
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        // Request stays up with a stable address until memory answers.
        if (imem_ack) begin
          instr_d       = imem_rdata;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (transfer) begin
          pc_d          = next_pc;
          fetch_count_d = fetch_count_q + 32'd1;
          instr_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          if (misaligned) begin
            imem_req_d = 1'b0;
            fault_d    = 1'b1;
            state_d    = FAULT;
          end else begin
            imem_req_d = 1'b1;
            state_d    = FETCH;
          end
`else
          imem_req_d    = 1'b1;
          state_d       = FETCH;
`endif
        end
      end
      FAULT: begin
        // Parked until reset; nothing is requested or presented.
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d       = IDLE;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0000;
      fetch_count_q <= 32'h0000_0000;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q       <= fault_d;
`endif
    end
  end

  // Every output comes straight from a register.
  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_count = fetch_count_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a protocol-level reference
// model updated on every clock edge, one compare process at the falling
// edge, directed scenarios with literal expectations, and a randomized
// soak with random ack latency, back-pressure, decode and resets.

module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump, jumpLink, jumpReg, branchatall, bne, zero;
  logic [15:0] imm;
  logic [31:0] addr;
  logic [31:0] reg_rs;
  logic [31:0] fetch_count;
  logic        fault;

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jumpLink    (jumpLink),
    .jumpReg     (jumpReg),
    .branchatall (branchatall),
    .bne         (bne),
    .zero        (zero),
    .imm         (imm),
    .addr        (addr),
    .reg_rs      (reg_rs),
    .fetch_count (fetch_count),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: expected values of every output in the current cycle
  logic [31:0] m_pc, m_instr, m_count;
  logic        m_req, m_valid, m_fault, m_idle;
  int          n_xfer;

  // counters and literal-check mailbox (written by compare process only)
  int          checks   = 0;
  int          failures = 0;
  bit          chk_en   = 1'b0;
  int          lit_seq  = 0;
  int          lit_done = 0;
  int          lit_sel  = 0;
  logic [31:0] lit_exp  = 32'h0;
  string       lit_name = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // single compare process: model vs DUT every cycle, plus posted literals
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("imem_req",    {31'b0, imem_req},    {31'b0, m_req});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("pc",          pc,                   m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("instr",       instr,                m_instr);
        chk("fetch_count", fetch_count,          m_count);
        chk("fault",       {31'b0, fault},       {31'b0, m_fault});
      end
      if (lit_seq != lit_done) begin
        lit_done = lit_seq;
        case (lit_sel)
          0: chk(lit_name, imem_addr,            lit_exp);
          1: chk(lit_name, fetch_count,          lit_exp);
          2: chk(lit_name, {31'b0, fault},       lit_exp);
          3: chk(lit_name, {31'b0, imem_req},    lit_exp);
          4: chk(lit_name, {31'b0, instr_valid}, lit_exp);
          default: begin
            checks++;
            failures++;
            $display("FAIL %s actual=timeout required=event t=%0t", lit_name, $time);
          end
        endcase
        $display("literal %s done", lit_name);
      end
    end
  end

  // post a literal check for the falling edge of the current cycle
  task automatic lit(input int sel, input logic [31:0] exp, input string name);
    lit_sel  = sel;
    lit_exp  = exp;
    lit_name = name;
    lit_seq++;
  endtask

  function automatic logic [31:0] model_next_pc();
    logic [31:0] t;
    int          off;
    if (jumpReg)                t = reg_rs;
    else if (jump || jumpLink)  t = addr;
    else if (branchatall && (zero != bne)) begin
      off = int'($signed(imm));
      t   = m_pc + 32'd4 + 32'(off * 4);
    end else                    t = m_pc + 32'd4;
    return t;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_count = 32'h0;
    m_req = 1'b0; m_valid = 1'b0; m_fault = 1'b0; m_idle = 1'b0;
  endtask

  // advance one clock: model sees the same inputs the DUT samples
  task automatic tick();
    logic [31:0] nxt;
    @(posedge clk);
    if (rst_n) begin
      if (m_idle) begin
        m_idle = 1'b0;
        m_req  = 1'b1;
      end else if (!m_fault) begin
        if (m_req && imem_ack) begin
          m_instr = imem_rdata;
          m_req   = 1'b0;
          m_valid = 1'b1;
        end else if (m_valid && instr_ready) begin
          nxt     = model_next_pc();
          m_count = m_count + 32'd1;
          m_valid = 1'b0;
          n_xfer++;
          $display("xfer %0d pc=%h next=%h", n_xfer, m_pc, nxt);
`ifdef FETCH_ALIGN_CHECK_EN
          m_pc = nxt;
          if (nxt[1:0] != 2'b00) m_fault = 1'b1;
          else                   m_req   = 1'b1;
`else
          m_pc  = nxt & 32'hFFFF_FFFC;
          m_req = 1'b1;
`endif
        end
      end
    end
    #1;
  endtask

  task automatic clear_dec();
    jump = 0; jumpLink = 0; jumpReg = 0; branchatall = 0; bne = 0; zero = 0;
    imm = 16'h0; addr = 32'h0; reg_rs = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n  = 1'b1;
    m_idle = 1'b1;
  endtask

  // wait for a held instruction, then accept it with the given decode
  task automatic do_xfer(input logic jr, input logic j, input logic jl,
                         input logic br, input logic bn, input logic z,
                         input logic [15:0] im, input logic [31:0] ad,
                         input logic [31:0] rs, input string name);
    int guard;
    imem_ack    = 1'b1;
    imem_rdata  = $urandom;
    instr_ready = 1'b0;
    guard = 0;
    while (!m_valid && guard < 20) begin
      tick();
      guard++;
    end
    if (!m_valid) begin
      lit(9, 32'h0, {name, "_timeout"});
      tick();
    end
    jumpReg = jr; jump = j; jumpLink = jl; branchatall = br; bne = bn; zero = z;
    imm = im; addr = ad; reg_rs = rs;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    clear_dec();
  endtask

  initial begin
    int guard;
    n_xfer      = 0;
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    clear_dec();
    model_reset();
    tick();
    chk_en = 1'b1;
    lit(3, 32'h0, "reset_req");
    tick();
    rst_n  = 1'b1;
    m_idle = 1'b1;

    // zero-wait memory, always ready, sequential code
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    guard = 0;
    while (n_xfer < 4 && guard < 40) begin
      imem_rdata = $urandom;
      tick();
      guard++;
    end
    instr_ready = 1'b0;
    if (n_xfer < 4) lit(9, 32'h0, "seq_timeout");
    else            lit(0, 32'h10, "seq_addr_after4");
    tick();
    lit(1, 32'd4, "seq_count4");
    tick();

    // branch / jump target selection
    do_xfer(0, 1, 0, 0, 0, 0, 16'h0,    32'h100, 32'h0,   "j100a");
    lit(0, 32'h100, "jump_0x100"); tick();
    do_xfer(0, 0, 0, 1, 0, 1, 16'hFFFE, 32'h0,   32'h0,   "beq_t");
    lit(0, 32'h0FC, "beq_taken"); tick();
    do_xfer(0, 1, 0, 0, 0, 0, 16'h0,    32'h100, 32'h0,   "j100b");
    do_xfer(0, 0, 0, 1, 0, 0, 16'hFFFE, 32'h0,   32'h0,   "beq_nt");
    lit(0, 32'h104, "beq_not_taken"); tick();
    do_xfer(0, 1, 0, 0, 0, 0, 16'h0,    32'h200, 32'h0,   "j200");
    do_xfer(1, 1, 0, 0, 0, 0, 16'h0,    32'h800, 32'h400, "jr");
    lit(0, 32'h400, "jumpreg_wins"); tick();
    do_xfer(0, 0, 1, 0, 0, 0, 16'h0,    32'h800, 32'h0,   "jal");
    lit(0, 32'h800, "jumplink"); tick();

    // slow memory and back-pressure: one request, one transfer
    do_xfer(0, 0, 0, 0, 0, 0, 16'h0, 32'h0, 32'h0, "seq");
    imem_ack = 1'b0;
    repeat (3) tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    lit(1, 32'd13, "stall_count"); tick();
    lit(0, 32'h808, "stall_addr");

    // reset while a request is outstanding, ack arriving during reset
    tick();
    rst_n = 1'b0;
    model_reset();
    imem_ack = 1'b1;
    lit(3, 32'h0, "rst_req_low");
    tick();
    lit(1, 32'h0, "rst_count");
    tick();
    rst_n  = 1'b1;
    m_idle = 1'b1;
    lit(0, 32'h0, "rst_refetch_pc");
    tick();
    lit(3, 32'h1, "rst_refetch_req");
    tick();

    // randomized soak
    for (int i = 0; i < 4000; i++) begin
      imem_ack    = ($urandom_range(0, 1) == 1);
      imem_rdata  = $urandom;
      instr_ready = ($urandom_range(0, 2) != 0);
      jumpReg     = ($urandom_range(0, 7) == 0);
      jump        = ($urandom_range(0, 7) == 0);
      jumpLink    = ($urandom_range(0, 7) == 0);
      branchatall = ($urandom_range(0, 2) == 0);
      bne         = $urandom_range(0, 1) == 1;
      zero        = $urandom_range(0, 1) == 1;
      imm         = 16'($urandom);
      addr        = $urandom;
      reg_rs      = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      addr[1:0]   = 2'b00;
      reg_rs[1:0] = 2'b00;
`endif
      if ($urandom_range(0, 499) == 0) do_reset();
      else                             tick();
    end
    clear_dec();
    instr_ready = 1'b0;

    // misaligned register target
    do_reset();
    do_xfer(1, 0, 0, 0, 0, 0, 16'h0, 32'h0, 32'h402, "jr_misaligned");
`ifdef FETCH_ALIGN_CHECK_EN
    lit(2, 32'h1, "fault_set"); tick();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    repeat (3) tick();
    lit(3, 32'h0, "fault_no_req"); tick();
    lit(4, 32'h0, "fault_no_valid"); tick();
    do_reset();
    lit(2, 32'h0, "fault_cleared"); tick();
`else
    lit(0, 32'h400, "jr_forced_aligned"); tick();
    lit(2, 32'h0, "fault_tied_low"); tick();
`endif
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
